// File: rtl/ex_wb_stage_pkg.sv
// Shared encodings for the lane-1 writeback stage: FSM states, fault codes and null register IDs.
package ex_wb_stage_pkg;

  typedef enum logic [1:0] {
    JX2_WBST_RUN   = 2'd0,
    JX2_WBST_STALL = 2'd1,
    JX2_WBST_FAULT = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    JX2_WBFLT_NONE = 2'b00,
    JX2_WBFLT_MEM  = 2'b01,
    JX2_WBFLT_HOLD = 2'b10
  } wb_fault_e;

  localparam logic [6:0] JX2_GR_ZZR = 7'h3F;
  localparam logic [6:0] JX2_CR_ZZR = 7'h3F;

  localparam logic [1:0] MEM_STAT_FAULT = 2'b11;

  function automatic logic is_mem_fault(input logic [1:0] stat);
    return stat == MEM_STAT_FAULT;
  endfunction

endpackage

// File: rtl/ex_wb_holdwdt.sv
// Stall watchdog: saturating count of consecutive held cycles, strobes when the next held edge hits the limit.
module ex_wb_holdwdt #(
  parameter int HOLD_LIMIT = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic frozen,
  input  logic clear,
  output logic timeout
);

  logic [3:0] cnt;

  // Frozen (fault) keeps the count; leaving the fault clears it.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= 4'd0;
    end else if (!frozen) begin
      if (!hold)
        cnt <= 4'd0;
      else if (cnt != 4'hF)
        cnt <= cnt + 4'd1;
    end
  end

  assign timeout = hold && (cnt == 4'(HOLD_LIMIT - 1));

endmodule

// File: rtl/ex_wb_stage.sv
// Lane-1 writeback: registers EX3 GPR/CR results into the regfile write port, with bubble
// insertion on stall, a hold-timeout watchdog and a memory-fault lockout until acknowledged.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int               GPR_W      = 7,
  parameter logic [GPR_W-1:0] ZZR_GPR    = JX2_GR_ZZR,
  parameter logic [GPR_W-1:0] ZZR_CR     = JX2_CR_ZZR,
  parameter int               HOLD_LIMIT = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       exHold,
  input  logic [GPR_W-1:0] regIdRn2,
  input  logic [63:0]      regValRn2,
  input  logic [GPR_W-1:0] regIdCn2,
  input  logic [63:0]      regValCn2,
  input  logic [1:0]       memDataOK,
  input  logic             wbFaultAck,
  output logic [GPR_W-1:0] regIdRnW,
  output logic [63:0]      regValRnW,
  output logic [GPR_W-1:0] regIdCnW,
  output logic [63:0]      regValCnW,
  output logic             wbFault,
  output logic [1:0]       wbFaultCode,
  output logic [31:0]      wbRetireCnt
);

  wb_state_e   state;
  wb_fault_e   fault_code;
  logic [31:0] retire_cnt;
  logic        stall, mem_flt, tmo_strobe, hold_tmo, flt_det, accept, ack_exit;
  logic        in_fault;
  logic        unused_hold_info;

  assign unused_hold_info = exHold[1];

  assign in_fault = (state == JX2_WBST_FAULT);
  assign stall    = exHold[0];
  assign mem_flt  = is_mem_fault(memDataOK);
  assign hold_tmo = (state == JX2_WBST_STALL) && tmo_strobe;
  assign flt_det  = !in_fault && (mem_flt || hold_tmo);
  assign accept   = !in_fault && !stall && !flt_det;
  assign ack_exit = in_fault && wbFaultAck;

  ex_wb_holdwdt #(.HOLD_LIMIT(HOLD_LIMIT)) u_holdwdt (
    .clock   (clock),
    .reset   (reset),
    .hold    (stall),
    .frozen  (in_fault),
    .clear   (ack_exit),
    .timeout (tmo_strobe)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= JX2_WBST_RUN;
      fault_code <= JX2_WBFLT_NONE;
      regIdRnW   <= ZZR_GPR;
      regIdCnW   <= ZZR_CR;
      regValRnW  <= 64'd0;
      regValCnW  <= 64'd0;
      retire_cnt <= 32'd0;
    end else begin
      // Non-accept cycles become bubbles; values stay put so only the IDs toggle.
      if (accept) begin
        regIdRnW  <= regIdRn2;
        regIdCnW  <= regIdCn2;
        regValRnW <= regValRn2;
        regValCnW <= regValCn2;
        if ((regIdRn2 != ZZR_GPR) || (regIdCn2 != ZZR_CR))
          retire_cnt <= retire_cnt + 32'd1;
      end else begin
        regIdRnW <= ZZR_GPR;
        regIdCnW <= ZZR_CR;
      end

      case (state)
        JX2_WBST_RUN: begin
          if (mem_flt) begin
            state      <= JX2_WBST_FAULT;
            fault_code <= JX2_WBFLT_MEM;
          end else if (stall) begin
            state <= JX2_WBST_STALL;
          end
        end
        JX2_WBST_STALL: begin
          if (mem_flt) begin
            state      <= JX2_WBST_FAULT;
            fault_code <= JX2_WBFLT_MEM;
          end else if (hold_tmo) begin
            state      <= JX2_WBST_FAULT;
            fault_code <= JX2_WBFLT_HOLD;
          end else if (!stall) begin
            state <= JX2_WBST_RUN;
          end
        end
        JX2_WBST_FAULT: begin
          if (wbFaultAck) begin
            state      <= JX2_WBST_RUN;
            fault_code <= JX2_WBFLT_NONE;
          end
        end
        default: begin
          state      <= JX2_WBST_RUN;
          fault_code <= JX2_WBFLT_NONE;
        end
      endcase
    end
  end

  assign wbFault     = in_fault;
  assign wbFaultCode = fault_code;
  assign wbRetireCnt = retire_cnt;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: reset, writeback, stall, memory fault, hold timeout, retire wrap.
module tb_ex_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  exHold;
  logic [6:0]  regIdRn2, regIdCn2;
  logic [63:0] regValRn2, regValCn2;
  logic [1:0]  memDataOK;
  logic        wbFaultAck;
  logic [6:0]  regIdRnW, regIdCnW;
  logic [63:0] regValRnW, regValCnW;
  logic        wbFault;
  logic [1:0]  wbFaultCode;
  logic [31:0] wbRetireCnt;

  int tests = 0;
  int fails = 0;

  ex_wb_stage #(.GPR_W(7), .ZZR_GPR(7'h3F), .ZZR_CR(7'h3F), .HOLD_LIMIT(12)) dut (
    .clock       (clock),
    .reset       (reset),
    .exHold      (exHold),
    .regIdRn2    (regIdRn2),
    .regValRn2   (regValRn2),
    .regIdCn2    (regIdCn2),
    .regValCn2   (regValCn2),
    .memDataOK   (memDataOK),
    .wbFaultAck  (wbFaultAck),
    .regIdRnW    (regIdRnW),
    .regValRnW   (regValRnW),
    .regIdCnW    (regIdCnW),
    .regValCnW   (regValCnW),
    .wbFault     (wbFault),
    .wbFaultCode (wbFaultCode),
    .wbRetireCnt (wbRetireCnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; exHold = 2'b00; memDataOK = 2'b00; wbFaultAck = 1'b0;
    regIdRn2 = 7'h3F; regIdCn2 = 7'h3F; regValRn2 = 64'd0; regValCn2 = 64'd0;
    step(); step();
    reset = 1'b0;
    check("rst_idR", 64'(regIdRnW), 64'h3F);
    check("rst_idC", 64'(regIdCnW), 64'h3F);
    check("rst_valR", regValRnW, 64'h0);
    check("rst_valC", regValCnW, 64'h0);
    check("rst_fault", 64'(wbFault), 64'h0);
    check("rst_code", 64'(wbFaultCode), 64'h0);
    check("rst_retire", 64'(wbRetireCnt), 64'h0);

    // normal writeback
    regIdRn2 = 7'h05; regValRn2 = 64'h1234;
    step();
    check("wb_idR", 64'(regIdRnW), 64'h05);
    check("wb_valR", regValRnW, 64'h1234);
    check("wb_idC", 64'(regIdCnW), 64'h3F);
    check("wb_retire", 64'(wbRetireCnt), 64'h1);
    regIdRn2 = 7'h3F;
    step();
    check("idle_retire", 64'(wbRetireCnt), 64'h1);

    // stall for 3 cycles, then release
    regIdRn2 = 7'h05; regValRn2 = 64'h55; regIdCn2 = 7'h10; regValCn2 = 64'hABC;
    exHold = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_idR", 64'(regIdRnW), 64'h3F);
      check("stall_idC", 64'(regIdCnW), 64'h3F);
      check("stall_retire", 64'(wbRetireCnt), 64'h1);
    end
    exHold = 2'b00;
    step();
    check("rel_idR", 64'(regIdRnW), 64'h05);
    check("rel_valR", regValRnW, 64'h55);
    check("rel_idC", 64'(regIdCnW), 64'h10);
    check("rel_valC", regValCnW, 64'hABC);
    check("rel_retire", 64'(wbRetireCnt), 64'h2);
    regIdRn2 = 7'h3F; regIdCn2 = 7'h3F;
    step();
    check("rel_once", 64'(regIdRnW), 64'h3F);
    check("rel_once_ret", 64'(wbRetireCnt), 64'h2);

    // memory fault
    regIdRn2 = 7'h07; regValRn2 = 64'h77; memDataOK = 2'b11;
    step();
    check("mf_fault", 64'(wbFault), 64'h1);
    check("mf_code", 64'(wbFaultCode), 64'h1);
    check("mf_idR", 64'(regIdRnW), 64'h3F);
    check("mf_valR_hold", regValRnW, 64'h55);
    check("mf_retire", 64'(wbRetireCnt), 64'h2);
    memDataOK = 2'b00;
    step();
    check("mf_stay", 64'(wbFault), 64'h1);
    check("mf_stay_idR", 64'(regIdRnW), 64'h3F);
    wbFaultAck = 1'b1;
    step();
    check("ack_fault", 64'(wbFault), 64'h0);
    check("ack_code", 64'(wbFaultCode), 64'h0);
    check("ack_idR", 64'(regIdRnW), 64'h3F);
    wbFaultAck = 1'b0; regIdRn2 = 7'h08; regValRn2 = 64'h88;
    step();
    check("post_ack_idR", 64'(regIdRnW), 64'h08);
    check("post_ack_valR", regValRnW, 64'h88);
    check("post_ack_ret", 64'(wbRetireCnt), 64'h3);

    // 11 held cycles then release: no timeout
    regIdRn2 = 7'h3F; exHold = 2'b01;
    for (int i = 0; i < 11; i++) step();
    check("h11_fault", 64'(wbFault), 64'h0);
    exHold = 2'b00;
    step();
    check("h11_rel_fault", 64'(wbFault), 64'h0);

    // 12 held cycles: timeout after 12th edge
    exHold = 2'b01;
    for (int i = 0; i < 11; i++) step();
    check("h12_pre", 64'(wbFault), 64'h0);
    step();
    check("h12_fault", 64'(wbFault), 64'h1);
    check("h12_code", 64'(wbFaultCode), 64'h2);
    check("h12_idR", 64'(regIdRnW), 64'h3F);
    exHold = 2'b00; wbFaultAck = 1'b1;
    step();
    check("h12_ack", 64'(wbFault), 64'h0);
    check("h12_ack_code", 64'(wbFaultCode), 64'h0);
    wbFaultAck = 1'b0; exHold = 2'b01;
    step();
    check("h12_restart", 64'(wbFault), 64'h0);
    exHold = 2'b00;
    step();

    // retire counter wrap
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    regIdRn2 = 7'h09; regValRn2 = 64'h99;
    step();
    check("wrap_idR", 64'(regIdRnW), 64'h09);
    check("wrap_retire", 64'(wbRetireCnt), 64'h0);

    // reset discards a latched fault
    regIdRn2 = 7'h0A; memDataOK = 2'b11;
    step();
    check("rf_fault", 64'(wbFault), 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0; memDataOK = 2'b00; regIdRn2 = 7'h3F;
    check("rf_clr_fault", 64'(wbFault), 64'h0);
    check("rf_clr_code", 64'(wbFaultCode), 64'h0);
    check("rf_clr_valR", regValRnW, 64'h0);
    check("rf_clr_ret", 64'(wbRetireCnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Writeback stage for lane 1, directly downstream of EX3. It registers EX3's final GPR and CR destination pairs into the register-file write port, one cycle after EX3 produces them. While the pipeline is held it inserts no-write bubbles, so a stalled result is never written twice. It also runs a stall watchdog and a memory-fault state machine that suppresses writeback until software or the control unit acknowledges the fault.

## Interface
Parameters:
- GPR_W, 7, width of GPR/CR register IDs
- ZZR_GPR, 7'h3F, null GPR ID (no write)
- ZZR_CR, 7'h3F, null CR ID (no write)
- HOLD_LIMIT, 12, consecutive held cycles that raise a timeout fault (2..15)

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- exHold  in  2  EX3 hold vector; bit0 = stall, bit1 = register held
- regIdRn2  in  GPR_W  EX3 GPR destination ID
- regValRn2  in  64  EX3 GPR destination value
- regIdCn2  in  GPR_W  EX3 CR destination ID
- regValCn2  in  64  EX3 CR destination value
- memDataOK  in  2  memory status; 2'b11 = fault, 2'b10 = busy
- wbFaultAck  in  1  clears a latched fault
- regIdRnW  out  GPR_W  GPR write ID to register file
- regValRnW  out  64  GPR write value
- regIdCnW  out  GPR_W  CR write ID
- regValCnW  out  64  CR write value
- wbFault  out  1  fault latched
- wbFaultCode  out  2  2'b00 none, 2'b01 memory fault, 2'b10 hold timeout
- wbRetireCnt  out  32  count of retired non-bubble writebacks

## Operation
- States are RUN, STALL and FAULT. Reset enters RUN.
- **Accept condition:** the state is not FAULT, exHold[0]=0, and no fault is being detected this cycle.
  - On accept, the EX3 IDs and values are registered into the *W outputs.
  - Otherwise the *W IDs load ZZR_GPR/ZZR_CR and the values hold their previous contents.
- **Hold counter:** 4-bit, saturating at 15.
  - Increments each cycle exHold[0]=1 while the state is not FAULT.
  - Clears when exHold[0]=0, and on FAULT exit.
- **RUN transitions:**
  - memDataOK=2'b11 → FAULT, code 01.
  - else exHold[0]=1 → STALL, counter becomes 1.
- **STALL transitions:**
  - memDataOK=2'b11 → FAULT, code 01. Memory fault has priority over timeout.
  - else exHold[0]=1 and counter=HOLD_LIMIT-1 → FAULT, code 10.
  - else exHold[0]=0 → RUN.
- **FAULT behaviour:**
  - wbFault=1 and writes are suppressed (IDs held at ZZR).
  - memDataOK and exHold are ignored.
  - wbFaultAck=1 → RUN; the code clears and the counter clears.
  - wbFaultAck is ignored outside FAULT.
- **Retire counter:** increments by 1 on an accept cycle when regIdRn2≠ZZR_GPR or regIdCn2≠ZZR_CR. It wraps modulo 2^32.
- exHold[1] is informational only and does not affect the stage.

## Timing
- Latency is 1 cycle: EX3 outputs at edge N appear on the *W ports after edge N+1.
- Reset values:
  - *W IDs = ZZR.
  - *W values = 0.
  - wbFault = 0, wbFaultCode = 0, wbRetireCnt = 0.
  - Counter = 0, state = RUN.
- Reset takes effect at the next edge from any state and discards any pending result or fault.
- When a fault is detected, the outputs after that edge are already bubble and wbFault=1. The faulting cycle's result is never written.
- Ack while in FAULT: the next cycle is in RUN and accepts normally if exHold[0]=0.
- Hold timeout: exHold[0] continuously high for HOLD_LIMIT cycles starting from RUN gives wbFault=1 after the HOLD_LIMIT-th edge.

## Structure
- Add to CoreDefs.v:
  - state encodings JX2_WBST_RUN/STALL/FAULT;
  - fault codes JX2_WBFLT_NONE/MEM/HOLD;
  - reuse of JX2_GR_ZZR/JX2_CR_ZZR as the ZZR defaults.
- One sub-module, ex_wb_holdwdt:
  - contains the saturating 4-bit hold counter and the compare against HOLD_LIMIT;
  - outputs a timeout strobe.
- The FSM, the write-port registers and the retire counter stay in ex_wb_stage.

## Test plan
- **Reset release:** hold reset for 2 cycles, then release → IDs=7'h3F, values=0, wbFault=0, wbRetireCnt=0.
- **Normal writeback:** present regIdRn2=7'h05, regValRn2=64'h1234 with exHold=0 → the next cycle shows regIdRnW=7'h05, regValRnW=64'h1234 and wbRetireCnt=1.
- **Stall then resume:** present ID 7'h05 with exHold[0]=1 for 3 cycles, then 0.
  - During the stall the IDs are 7'h3F and there are no retires.
  - After release, 7'h05 is written exactly once and the retire count rises by 1.
- **Memory fault:** memDataOK=2'b11 alongside ID 7'h07 → wbFault=1, code 01, and 7'h07 is never written. Then pulse wbFaultAck → RUN, code 00, and the next valid result writes.
- **Hold timeout:** exHold[0]=1 for 12 cycles with HOLD_LIMIT=12 → wbFault=1, code 10 after the 12th edge. With 11 cycles followed by a release there is no fault.
- **Retire counter wrap:** preload wbRetireCnt=32'hFFFFFFFF by force, then retire one write → the counter reads 0.
